multi_chng_det: RTL and testbench
=================================

// Module: multi_chng_det
// PURPOSE
//  Parametrised multi-channel change detector, successor to the single-bit detector.
//  Per channel: glitch-filters a raw input, outputs the filtered level and a 1-cycle
//  detect pulse on the selected edge(s). Also keeps a sticky flag and a saturating
//  event counter. Sits between raw control/status inputs and the interrupt/status
//  register logic.
// PARAMETERS
//  NCH      4  number of independent channels
//  FILT_LEN 3  consecutive differing samples needed to accept a new level (>=1)
//  CNT_W    8  width of each per-channel event counter (saturating)
// PORTS
//  clk        in   1          single clock; all logic on posedge clk
//  rst        in   1          synchronous, active-high reset
//  sig        in   NCH        raw input levels
//  mode       in   2          00 off, 01 rise, 10 fall, 11 both (common to all channels)
//  clr        in   1          clears sticky flags and event counters
//  chngd_sig  out  NCH        filtered level per channel
//  det_out    out  NCH        1-cycle detect pulse per channel
//  det_any    out  1          registered OR of the det_out next-state values
//  sticky     out  NCH        set on detect; cleared by clr
//  evt_cnt    out  NCH*CNT_W  per-channel detect counts; ch i at [i*CNT_W +: CNT_W]
// BEHAVIOUR
//  - Reset (rst=1 at posedge): chngd_sig=0, det_out=0, det_any=0, sticky=0, evt_cnt=0.
//    Filter counters are 0 and each channel is in IDLE. rst overrides clr and all events.
//  - Per-channel FSM: IDLE (r==lvl) and QUAL (r!=lvl, counting). r is the sampled input.
//    Every posedge:
//    - r==lvl: cnt<=0, state IDLE. A glitch shorter than FILT_LEN is discarded.
//    - r!=lvl, cnt<FILT_LEN-1: cnt<=cnt+1, state QUAL.
//    - r!=lvl, cnt==FILT_LEN-1: lvl<=r, cnt<=0, state IDLE; raise the edge event.
//  - Latency: for an input first differing at edge k, chngd_sig updates at edge
//    k+FILT_LEN-1. FILT_LEN=1 updates at edge k.
//  - det_out[i]=1 for exactly the first cycle of the new chngd_sig value, and only if
//    the edge matches mode. Rise = lvl 0->1, fall = lvl 1->0. mode=00 never pulses.
//  - Changing mode never disturbs filtering; mode is sampled at the accepting edge.
//  - A detect sets sticky[i] and increments evt_cnt[i]. evt_cnt saturates at
//    2^CNT_W-1 and never wraps.
//  - clr and a detect in the same cycle: the event wins over the clear, giving
//    sticky=1 and cnt=1.
//  - Channels are fully independent; simultaneous detects on several channels are all
//    reported in the same cycle.
//  - The level after reset is 0. An input held high through reset produces a rising
//    event FILT_LEN edges after rst deasserts.
// CONFIGURATION
//  - MULTI_CHNG_DET_SYNC_EN defined: each sig bit passes through a 2-flop synchronizer
//    before the filter. This adds exactly 2 cycles to every latency. Synchronizer flops
//    reset to 0.
//  - Not defined: r=sig directly; the input must already be synchronous to clk.
// STRUCTURE
//  - chng_det_pkg holds the mode typedef (MODE_OFF/RISE/FALL/BOTH), the FSM state typedef
//    (ST_IDLE/ST_QUAL), and the helper function for the filter counter width
//    ($clog2(FILT_LEN) min 1).
//  - Sub-module chng_det_ch covers one channel: synchronizer (optional), filter FSM, edge
//    qualify, sticky and counter. The top generates NCH instances plus the det_any OR.
// TESTING (NCH=4, FILT_LEN=3, CNT_W=4, macro undefined unless stated)
//  1. rst=1 for 2 cycles with sig=4'hF, then mode=11 -> all outputs 0 during reset.
//     chngd_sig=4'hF and det_out=4'hF at the 3rd edge after release; evt_cnt each 1.
//  2. Glitch: sig[0] high 2 cycles, then low -> chngd_sig[0] stays 0, no det_out,
//     evt_cnt[0]=0.
//  3. mode=01: sig[1] 0->1 for 5 cycles, then 0 for 5 cycles -> one det_out[1] pulse on
//     the rise only; evt_cnt[1]=1, sticky[1]=1.
//  4. mode=11: sig[2] toggled every 4 cycles, 20 times -> 20 accepted edges; evt_cnt[2]
//     saturates at 15.
//  5. clr asserted on the same cycle as det_out[3] -> sticky[3]=1, evt_cnt[3]=1; clr
//     alone next cycle -> both 0.
//  6. sig[0] goes high, rst pulses after 2 qualifying cycles -> no pulse, chngd_sig[0]=0.
//     Qualification restarts and accepts 3 edges after release. With the macro defined,
//     repeat case 3: the pulse arrives 2 cycles later.

Source files
------------

// File: rtl/chng_det_pkg.sv
// Shared types and helpers for the multi-channel change detector.
// Build option: MULTI_CHNG_DET_SYNC_EN adds a 2-flop input synchronizer per channel.
package chng_det_pkg;

   typedef enum logic [1:0] {
      MODE_OFF  = 2'b00,
      MODE_RISE = 2'b01,
      MODE_FALL = 2'b10,
      MODE_BOTH = 2'b11
   } mode_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_QUAL = 1'b1
   } state_e;

   // Filter counter only has to reach FILT_LEN-1; keep at least one bit.
   function automatic int filt_cnt_w(input int filt_len);
      int w;
      w = $clog2(filt_len);
      if (w < 1) w = 1;
      return w;
   endfunction

endpackage

// File: rtl/chng_det_ch.sv
// One detector channel: optional synchronizer, glitch filter FSM, edge qualify,
// sticky flag and saturating event counter. Build option: MULTI_CHNG_DET_SYNC_EN.
module chng_det_ch
   import chng_det_pkg::*;
#(
   parameter int FILT_LEN = 3,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             sig_i,
   input  mode_e            mode_i,
   input  logic             clr_i,
   output logic             lvl_o,
   output logic             det_o,
   output logic             det_d_o,
   output logic             sticky_o,
   output logic [CNT_W-1:0] evt_cnt_o,
   output state_e           state_o
);

   localparam int               CW       = filt_cnt_w(FILT_LEN);
   localparam logic [CW-1:0]    CNT_LAST = CW'(FILT_LEN - 1);
   localparam logic [CNT_W-1:0] EVT_MAX  = '1;

   logic r;

`ifdef MULTI_CHNG_DET_SYNC_EN
   logic sync1_q, sync1_d, sync2_q, sync2_d;

   always_comb begin
      sync1_d = sig_i;
      sync2_d = sync1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
      end
   end

   assign r = sync2_q;
`else
   assign r = sig_i;
`endif

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             lvl_q, lvl_d;
   logic             accept;
   logic             det_q, det_d;
   logic             sticky_q, sticky_d;
   logic [CNT_W-1:0] evt_q, evt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         lvl_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lvl_q   <= lvl_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lvl_d   = lvl_q;
      accept  = 1'b0;
      if (r == lvl_q) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
      end else if (cnt_q == CNT_LAST) begin
         state_d = ST_IDLE;
         cnt_d   = '0;
         lvl_d   = r;
         accept  = 1'b1;
      end else begin
         state_d = ST_QUAL;
         cnt_d   = cnt_q + 1'b1;
      end
   end

   // Mode is looked at only on the accepting edge; a new event beats a same-cycle clear.
   always_comb begin
      det_d = 1'b0;
      unique case (mode_i)
         MODE_RISE: det_d = accept & r;
         MODE_FALL: det_d = accept & ~r;
         MODE_BOTH: det_d = accept;
         default:   det_d = 1'b0;
      endcase
      sticky_d = clr_i ? 1'b0 : sticky_q;
      evt_d    = clr_i ? '0 : evt_q;
      if (det_d) begin
         sticky_d = 1'b1;
         if (clr_i)                evt_d = CNT_W'(1);
         else if (evt_q != EVT_MAX) evt_d = evt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         det_q    <= 1'b0;
         sticky_q <= 1'b0;
         evt_q    <= '0;
      end else begin
         det_q    <= det_d;
         sticky_q <= sticky_d;
         evt_q    <= evt_d;
      end
   end

   assign lvl_o     = lvl_q;
   assign det_o     = det_q;
   assign det_d_o   = det_d;
   assign sticky_o  = sticky_q;
   assign evt_cnt_o = evt_q;
   assign state_o   = state_q;

endmodule

// File: rtl/multi_chng_det.sv
// Multi-channel glitch-filtered change detector with sticky flags and event counters.
// Build option: MULTI_CHNG_DET_SYNC_EN adds a 2-flop synchronizer on every input bit.
module multi_chng_det
   import chng_det_pkg::*;
#(
   parameter int NCH      = 4,
   parameter int FILT_LEN = 3,
   parameter int CNT_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCH-1:0]       sig,
   input  logic [1:0]           mode,
   input  logic                 clr,
   output logic [NCH-1:0]       chngd_sig,
   output logic [NCH-1:0]       det_out,
   output logic                 det_any,
   output logic [NCH-1:0]       sticky,
   output logic [NCH*CNT_W-1:0] evt_cnt,
   output logic [NCH-1:0]       dbg_state
);

   logic [NCH-1:0] det_d_all;
   logic           det_any_q, det_any_d;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      chng_det_ch #(
         .FILT_LEN (FILT_LEN),
         .CNT_W    (CNT_W)
      ) u_ch (
         .clk       (clk),
         .rst       (rst),
         .sig_i     (sig[g]),
         .mode_i    (mode_e'(mode)),
         .clr_i     (clr),
         .lvl_o     (chngd_sig[g]),
         .det_o     (det_out[g]),
         .det_d_o   (det_d_all[g]),
         .sticky_o  (sticky[g]),
         .evt_cnt_o (evt_cnt[g*CNT_W +: CNT_W]),
         .state_o   (dbg_state[g])
      );
   end

   // Registered from next-state values so det_any lines up with det_out.
   always_comb det_any_d = |det_d_all;

   always_ff @(posedge clk) begin
      if (rst) det_any_q <= 1'b0;
      else     det_any_q <= det_any_d;
   end

   assign det_any = det_any_q;

endmodule

// File: tb/tb_multi_chng_det.sv
// Self-checking bench for multi_chng_det (NCH=4, FILT_LEN=3, CNT_W=4).
// Build option: MULTI_CHNG_DET_SYNC_EN shifts all expected latencies by 2 cycles.
module tb_multi_chng_det;

`ifdef MULTI_CHNG_DET_SYNC_EN
   localparam int D = 2;
`else
   localparam int D = 0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  sig;
   logic [1:0]  mode;
   logic        clr;
   logic [3:0]  chngd_sig;
   logic [3:0]  det_out;
   logic        det_any;
   logic [3:0]  sticky;
   logic [15:0] evt_cnt;
   logic [3:0]  dbg_state;

   logic [8:0]  exp_q[$];
   int          checks = 0;
   int          errors = 0;

   multi_chng_det #(.NCH(4), .FILT_LEN(3), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .sig       (sig),
      .mode      (mode),
      .clr       (clr),
      .chngd_sig (chngd_sig),
      .det_out   (det_out),
      .det_any   (det_any),
      .sticky    (sticky),
      .evt_cnt   (evt_cnt),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; sig = 4'h0; clr = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      logic [8:0] exp_v;
      rst = 1'b1; sig = 4'hF; mode = 2'b00; clr = 1'b0;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({chngd_sig, det_out, det_any, sticky, evt_cnt} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", {chngd_sig, det_out, det_any, sticky, evt_cnt});
         end
      end
      rst = 1'b0; mode = 2'b11;
      for (int e = 1; e <= 3 + D; e++) begin
         exp_q.push_back((e == 3 + D) ? 9'h1FF : ((e > 3 + D) ? 9'h1E0 : 9'h000));
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL reset_release e=%0d: got %h expected %h", e, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
      checks++;
      if (evt_cnt !== 16'h1111 || sticky !== 4'hF) begin
         errors++;
         $display("FAIL reset_counts: got evt=%h sticky=%h expected 1111/f", evt_cnt, sticky);
      end
      tick();
      checks++;
      if ({chngd_sig, det_out, det_any} !== 9'h1E0) begin
         errors++;
         $display("FAIL reset_pulse_end: got %h expected 1e0", {chngd_sig, det_out, det_any});
      end
   endtask

   task automatic test_glitch();
      logic [8:0] exp_v;
      do_reset();
      mode = 2'b11;
      for (int e = 1; e <= 8 + D; e++) begin
         sig = (e <= 2) ? 4'h1 : 4'h0;
         exp_q.push_back(9'h000);
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL glitch e=%0d: got %h expected %h", e, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
      checks++;
      if (evt_cnt[3:0] !== 4'd0 || sticky !== 4'h0) begin
         errors++;
         $display("FAIL glitch_counts: got evt0=%0d sticky=%h expected 0/0", evt_cnt[3:0], sticky);
      end
   endtask

   // Pulse expected only on the edge type(s) selected by mode.
   task automatic test_edge(input logic [1:0] m, input logic [3:0] pat, input string name);
      logic [8:0] exp_v;
      logic [3:0] ex_lvl, ex_det;
      logic [3:0] ex_cnt;
      do_reset();
      mode = m;
      ex_cnt = 4'd0;
      for (int e = 1; e <= 12 + D; e++) begin
         sig    = (e <= 5) ? pat : 4'h0;
         ex_lvl = (e >= 3 + D && e <= 7 + D) ? pat : 4'h0;
         ex_det = 4'h0;
         if (e == 3 + D && m[0]) ex_det = pat;
         if (e == 8 + D && m[1]) ex_det = pat;
         if (ex_det != 4'h0) ex_cnt = ex_cnt + 4'd1;
         exp_q.push_back({ex_lvl, ex_det, |ex_det});
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL %s e=%0d: got %h expected %h", name, e, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
      for (int c = 0; c < 4; c++) begin
         checks++;
         if (evt_cnt[c*4 +: 4] !== (pat[c] ? ex_cnt : 4'd0) || sticky[c] !== (pat[c] && ex_cnt != 0)) begin
            errors++;
            $display("FAIL %s_counts ch%0d: got evt=%0d sticky=%b expected %0d", name, c, evt_cnt[c*4 +: 4], sticky[c], pat[c] ? ex_cnt : 4'd0);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic [8:0] exp_v;
      do_reset();
      for (int e = 1; e <= 4 + D; e++) begin
         mode = (e < 3 + D) ? 2'b00 : 2'b01;
         sig  = 4'h2;
         exp_q.push_back({(e >= 3 + D) ? 4'h2 : 4'h0, (e == 3 + D) ? 4'h2 : 4'h0, e == 3 + D});
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL mode_switch e=%0d: got %h expected %h", e, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
   endtask

   task automatic test_saturate();
      logic [8:0] exp_v;
      logic       s_hist[1:100];
      logic       ex_lvl, prev_lvl, ex_det;
      logic [3:0] ex_cnt;
      int         idx;
      do_reset();
      mode = 2'b11;
      prev_lvl = 1'b0;
      ex_cnt = 4'd0;
      for (int e = 1; e <= 86 + D; e++) begin
         s_hist[e] = (e <= 80) && (((e - 1) / 4) % 2 == 0);
         sig = {1'b0, s_hist[e], 2'b00};
         idx = e - 2 - D;
         ex_lvl = (idx >= 1) ? s_hist[idx] : 1'b0;
         ex_det = ex_lvl != prev_lvl;
         prev_lvl = ex_lvl;
         if (ex_det && ex_cnt != 4'd15) ex_cnt = ex_cnt + 4'd1;
         exp_q.push_back({1'b0, ex_lvl, 2'b00, 1'b0, ex_det, 2'b00, ex_det});
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v || evt_cnt[11:8] !== ex_cnt) begin
            errors++;
            $display("FAIL saturate e=%0d: got %h cnt=%0d expected %h cnt=%0d", e, {chngd_sig, det_out, det_any}, evt_cnt[11:8], exp_v, ex_cnt);
         end
      end
      checks++;
      if (evt_cnt[11:8] !== 4'd15) begin
         errors++;
         $display("FAIL saturate_final: got %0d expected 15", evt_cnt[11:8]);
      end
   endtask

   task automatic test_clr_collision();
      logic [8:0] exp_v;
      do_reset();
      mode = 2'b11;
      for (int e = 1; e <= 3 + D; e++) begin
         sig = 4'h8;
         clr = (e == 3 + D);
         exp_q.push_back({(e == 3 + D) ? 4'h8 : 4'h0, (e == 3 + D) ? 4'h8 : 4'h0, e == 3 + D});
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL clr_collision e=%0d: got %h expected %h", e, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
      checks++;
      if (sticky[3] !== 1'b1 || evt_cnt[15:12] !== 4'd1) begin
         errors++;
         $display("FAIL clr_event_wins: got sticky=%b evt=%0d expected 1/1", sticky[3], evt_cnt[15:12]);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      checks++;
      if (sticky !== 4'h0 || evt_cnt !== 16'h0000 || det_out !== 4'h0) begin
         errors++;
         $display("FAIL clr_alone: got sticky=%h evt=%h det=%h expected 0/0/0", sticky, evt_cnt, det_out);
      end
   endtask

   task automatic test_rst_mid();
      logic [8:0] exp_v;
      do_reset();
      mode = 2'b11;
      sig = 4'h1;
      for (int e = 1; e <= 2; e++) begin
         tick();
         checks++;
         if ({chngd_sig, det_out} !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid_qual e=%0d: got %h expected 00", e, {chngd_sig, det_out});
         end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if ({chngd_sig, det_out, det_any, dbg_state} !== 13'd0) begin
         errors++;
         $display("FAIL rst_mid_reset: got %h expected 0", {chngd_sig, det_out, det_any, dbg_state});
      end
      for (int k = 1; k <= 4 + D; k++) begin
         exp_q.push_back({(k >= 3 + D) ? 4'h1 : 4'h0, (k == 3 + D) ? 4'h1 : 4'h0, k == 3 + D});
         tick();
         exp_v = exp_q.pop_front();
         checks++;
         if ({chngd_sig, det_out, det_any} !== exp_v) begin
            errors++;
            $display("FAIL rst_mid_release k=%0d: got %h expected %h", k, {chngd_sig, det_out, det_any}, exp_v);
         end
      end
   endtask

   initial begin
      rst = 1'b1; sig = 4'h0; mode = 2'b00; clr = 1'b0;
      test_reset();
      test_glitch();
      test_edge(2'b01, 4'h2, "rise_only");
      test_edge(2'b10, 4'hF, "fall_only");
      test_edge(2'b11, 4'h5, "both_edges");
      test_edge(2'b00, 4'hA, "mode_off");
      test_mode_switch();
      test_saturate();
      test_clr_collision();
      test_rst_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
